// File: rtl/ram_master_if.sv
// ram_master_if: core-side request/beat handshake of the RAM bus initiator.
//   master modport : the requesting core (drives req_*, wr_valid, wr_data)
//   slave modport  : ram_master (drives req_ready, wr_ready, rd_*, done)
interface ram_master_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;

    modport master (
        output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, done
    );
endinterface

// File: rtl/ram_master.sv
// ram_master: burst initiator for a single-port synchronous RAM.
//   clk, rst      : single clock, asynchronous active-high reset
//   core          : request / write-beat / read-beat handshake (slave side)
//   ram_cs/we/oe  : RAM chip select, write enable, output enable
//   ram_addr      : RAM address (wraps modulo 2^ADDR_WIDTH)
//   ram_data      : shared bidirectional data bus, driven only on write beats
module ram_master #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_master_if.slave           core,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic                  drive_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        done_d         = 1'b0;
        core.req_ready = 1'b0;
        core.wr_ready  = 1'b0;
        ram_cs         = 1'b0;
        ram_we         = 1'b0;
        ram_oe         = 1'b0;
        drive_en       = 1'b0;

        case (state_q)
            IDLE: begin
                // After a write the done pulse lands in IDLE; hold off the
                // next request until that pulse has been seen.
                core.req_ready = ~done_q;
                if (core.req_valid && !done_q) begin
                    addr_d  = core.req_addr;
                    cnt_d   = core.req_len;
                    state_d = core.req_we ? WR : RD;
                end
            end
            WR: begin
                core.wr_ready = 1'b1;
                // A cycle without wr_valid is a stall: no RAM access at all.
                ram_cs   = core.wr_valid;
                ram_we   = core.wr_valid;
                drive_en = core.wr_valid;
                if (core.wr_valid) begin
                    addr_d = addr_q + 1'b1;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            RD: begin
                ram_cs     = 1'b1;
                ram_oe     = 1'b1;
                rd_data_d  = ram_data;
                rd_valid_d = 1'b1;
                addr_d     = addr_q + 1'b1;
                if (cnt_q == '0) begin
                    // done rides with the final rd_valid in TURN.
                    done_d  = 1'b1;
                    state_d = TURN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TURN: begin
                // Controls low for one cycle so the RAM releases the bus.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_addr      = addr_q;
    assign ram_data      = drive_en ? core.wr_data : {DATA_WIDTH{1'bz}};
    assign core.rd_valid = rd_valid_q;
    assign core.rd_data  = rd_data_q;
    assign core.done     = done_q;

endmodule

// File: tb/tb_ram_master.sv
module tb_ram_master;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    ram_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) cif ();

    ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .core(cif),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // RAM model: writes on posedge, latches reads on negedge, drives while selected for read.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    always @(negedge clk) if (ram_cs && ram_oe && !ram_we) ram_q <= mem[ram_addr];

    // Reference memory contents, updated from the stimulus itself.
    logic [DW-1:0] ref_mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor (sampled mid-cycle).
    int we_cycles = 0, wr_cycles = 0, done_cnt = 0, done_cyc = 0;
    int viol = 0, gap_viol = 0;
    logic prev_oe = 1'b0;
    logic done_rdy = 1'b0;
    logic [DW-1:0] rd_q[$];
    int rdc_q[$];
    logic [DW-1:0] wq[$];

    always @(negedge clk) begin
        if (ram_cs && ram_we) we_cycles++;
        if (cif.wr_ready) wr_cycles++;
        if (ram_we && ram_oe) viol++;
        if (ram_cs && ram_we && prev_oe) gap_viol++;
        prev_oe = ram_oe;
        if (cif.rd_valid) begin
            rd_q.push_back(cif.rd_data);
            rdc_q.push_back(cyc);
        end
        if (cif.done) begin
            done_cnt++;
            done_cyc = cyc;
            done_rdy = cif.req_ready;
        end
    end

    function automatic int wrap(input int a, input int i);
        return (a + i) % DEPTH;
    endfunction

    // Issue a request and return at posedge+1 of the first burst cycle.
    task automatic send_req(input logic we, input int a, input int l);
        int t = 0;
        cif.req_valid = 1'b1;
        cif.req_we    = we;
        cif.req_addr  = AW'(a);
        cif.req_len   = LW'(l);
        @(negedge clk);
        while (!cif.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            errors++; checks++;
            $display("FAIL req_accept: req_ready stayed %0b, required 1", cif.req_ready);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        // Later request changes must be ignored.
        cif.req_valid = 1'b0;
        cif.req_we    = 1'($urandom);
        cif.req_addr  = AW'($urandom);
        cif.req_len   = LW'($urandom);
    endtask

    // Write burst of wq; stalls randomly (pct) and for s1 cycles after the first beat.
    task automatic do_write(input int a, input int l, input int pct, input int s1, input string nm);
        int i = 0, tot = 0, s = s1;
        int w0, we0, d0;
        send_req(1'b1, a, l);
        w0 = wr_cycles; we0 = we_cycles; d0 = done_cnt;
        while (i <= l) begin
            if (i == 1 && s > 0) begin
                cif.wr_valid = 1'b0; s--;
                cif.wr_data = DW'($urandom);
            end else if (int'($urandom_range(0, 99)) < pct) begin
                cif.wr_valid = 1'b0;
                cif.wr_data = DW'($urandom);
            end else begin
                cif.wr_valid = 1'b1;
                cif.wr_data  = wq[i];
                ref_mem[wrap(a, i)] = wq[i];
                i++;
            end
            tot++;
            @(posedge clk); #1;
        end
        cif.wr_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (wr_cycles - w0 !== tot) begin errors++;
            $display("FAIL %s wr_cycles: got %0d required %0d", nm, wr_cycles - w0, tot); end
        checks++; if (we_cycles - we0 !== l + 1) begin errors++;
            $display("FAIL %s ram_we_cycles: got %0d required %0d", nm, we_cycles - we0, l + 1); end
        checks++; if (done_cnt - d0 !== 1) begin errors++;
            $display("FAIL %s done_count: got %0d required 1", nm, done_cnt - d0); end
        checks++; if (done_cyc !== acc_cyc + tot) begin errors++;
            $display("FAIL %s done_cycle: got %0d required %0d", nm, done_cyc, acc_cyc + tot); end
        checks++; if (done_rdy !== 1'b0) begin errors++;
            $display("FAIL %s req_ready_in_done_cycle: got %0b required 0", nm, done_rdy); end
        for (int k = 0; k <= l; k++) begin
            checks++; if (mem[wrap(a, k)] !== wq[k]) begin errors++;
                $display("FAIL %s ram[%0h]: got %0h required %0h", nm, wrap(a, k), mem[wrap(a, k)], wq[k]); end
        end
    endtask

    task automatic do_read(input int a, input int l, input string nm);
        int d0;
        rd_q.delete(); rdc_q.delete();
        d0 = done_cnt;
        send_req(1'b0, a, l);
        repeat (l + 3) @(posedge clk);
        #1;
        checks++; if (rd_q.size() !== l + 1) begin errors++;
            $display("FAIL %s rd_beats: got %0d required %0d", nm, rd_q.size(), l + 1); end
        for (int k = 0; k <= l && k < rd_q.size(); k++) begin
            checks++; if (rd_q[k] !== ref_mem[wrap(a, k)] || rdc_q[k] !== acc_cyc + 1 + k) begin errors++;
                $display("FAIL %s rd_beat%0d: got %0h@%0d required %0h@%0d", nm, k, rd_q[k], rdc_q[k],
                         ref_mem[wrap(a, k)], acc_cyc + 1 + k); end
        end
        checks++; if (done_cnt - d0 !== 1 || done_cyc !== acc_cyc + l + 1) begin errors++;
            $display("FAIL %s rd_done: got %0d pulses@%0d required 1@%0d", nm, done_cnt - d0, done_cyc,
                     acc_cyc + l + 1); end
    endtask

    task automatic fill_wq(input int l);
        wq.delete();
        for (int k = 0; k <= l; k++) wq.push_back(DW'($urandom));
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({cif.req_ready, cif.wr_ready, cif.rd_valid, cif.done} !== 4'b1000) begin errors++;
            $display("FAIL reset_hs: got %b required 1000", {cif.req_ready, cif.wr_ready, cif.rd_valid, cif.done}); end
        checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin errors++;
            $display("FAIL reset_ctl: got %b required 000", {ram_cs, ram_we, ram_oe}); end
        checks++; if (ram_addr !== '0 || cif.rd_data !== '0) begin errors++;
            $display("FAIL reset_regs: got addr %0h data %0h required 0 0", ram_addr, cif.rd_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cif.req_ready !== 1'b1 || ram_cs !== 1'b0) begin errors++;
            $display("FAIL reset_release: got rdy %0b cs %0b required 1 0", cif.req_ready, ram_cs); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        wq.delete(); wq.push_back(8'hA5);
        do_write(32'h0010, 0, 0, 0, "single_wr");
        do_read(32'h0010, 0, "single_rd");
        checks++; if (rd_q.size() < 1 || rd_q[0] !== 8'hA5) begin errors++;
            $display("FAIL single_rd_value: got %0h required a5", rd_q.size() > 0 ? rd_q[0] : 8'h00); end
    endtask

    task automatic test_write_stall();
        wq.delete();
        wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
        do_write(32'h0100, 3, 0, 2, "wr_stall");
    endtask

    task automatic test_read_wrap();
        mem[13'h1FFE] = 8'h01; ref_mem[13'h1FFE] = 8'h01;
        mem[13'h1FFF] = 8'h02; ref_mem[13'h1FFF] = 8'h02;
        mem[13'h0000] = 8'h03; ref_mem[13'h0000] = 8'h03;
        do_read(32'h1FFE, 2, "rd_wrap");
    endtask

    task automatic test_read_then_write();
        int a = int'($urandom_range(0, DEPTH - 1));
        int l = int'($urandom_range(0, 7));
        int g0 = gap_viol;
        do_read(a, l, "rw_rd");
        fill_wq(l);
        do_write(a, l, 25, 0, "rw_wr");
        do_read(a, l, "rw_rd2");
        checks++; if (gap_viol - g0 !== 0) begin errors++;
            $display("FAIL rw_turn_gap: got %0d direct oe->we transitions required 0", gap_viol - g0); end
        checks++; if (viol !== 0) begin errors++;
            $display("FAIL bus_contention: got %0d we&oe cycles required 0", viol); end
    endtask

    task automatic test_reset_mid();
        int r0, d0;
        send_req(1'b0, int'($urandom_range(0, DEPTH - 1)), 3);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin errors++;
            $display("FAIL rstmid_ctl: got %b required 000", {ram_cs, ram_we, ram_oe}); end
        checks++; if ({cif.req_ready, cif.rd_valid, cif.done} !== 3'b100) begin errors++;
            $display("FAIL rstmid_hs: got %b required 100", {cif.req_ready, cif.rd_valid, cif.done}); end
        @(posedge clk); #1;
        rst = 1'b0;
        r0 = rd_q.size(); d0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (rd_q.size() - r0 !== 0 || done_cnt - d0 !== 0) begin errors++;
            $display("FAIL rstmid_after: got %0d rd_valid %0d done required 0 0", rd_q.size() - r0, done_cnt - d0); end
        checks++; if (cif.req_ready !== 1'b1) begin errors++;
            $display("FAIL rstmid_ready: got %0b required 1", cif.req_ready); end
    endtask

    task automatic test_max_burst();
        fill_wq(15);
        do_write(32'h0FF8, 15, 0, 0, "max_wr");
        do_read(32'h0FF8, 15, "max_rd");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 16, DEPTH - 1))
                                                : int'($urandom_range(0, DEPTH - 1));
            int l = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                fill_wq(l);
                do_write(a, l, 30, 0, "rand_wr");
            end else begin
                do_read(a, l, "rand_rd");
            end
        end
    endtask

    initial begin
        cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_addr = '0; cif.req_len = '0;
        cif.wr_valid = 1'b0; cif.wr_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = '0;
            ref_mem[k] = '0;
        end
        ram_q = '0;
        test_reset();
        test_single();
        test_write_stall();
        test_read_wrap();
        test_read_then_write();
        test_reset_mid();
        test_max_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
